if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 21 ++
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory read port between fetch unit and memory
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with one-entry output slot and branch redirect
// Optional bubble counter output enabled by defining FETCH_BUBBLE_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    if_fetch_unit_if.master      imem,
    output logic [31:0]          instn_out,
    output logic [31:0]          currpc,
    output logic [31:0]          nextpc,
    output logic                 instn_valid
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [15:0]          bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instn_q, instn_d;
    logic [31:0] currpc_q, currpc_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic        valid_q, valid_d;
    logic        req_int;
    logic        ack_int;

    // FETCH only issues when the slot is free or being drained this cycle.
    assign req_int = (state_q != S_FETCH) || !valid_q || !stall;
    assign ack_int = req_int && imem.imem_ack;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instn_d  = instn_q;
        currpc_d = currpc_q;
        nextpc_d = nextpc_q;
        valid_d  = valid_q && stall;
        if (branch_taken) begin
            pc_d    = branch_target & 32'hFFFF_FFFC;
            valid_d = 1'b0;
            state_d = (req_int && !imem.imem_ack) ? S_DISCARD : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH, S_WAIT: begin
                    if (ack_int) begin
                        instn_d  = imem.imem_rdata;
                        currpc_d = pc_q;
                        nextpc_d = pc_q + 32'd4;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_FETCH;
                    end else if (req_int) begin
                        state_d = S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (ack_int) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instn_q  <= 32'd0;
            currpc_q <= 32'd0;
            nextpc_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instn_q  <= instn_d;
            currpc_q <= currpc_d;
            nextpc_q <= nextpc_d;
            valid_q  <= valid_d;
        end
    end

    assign imem.imem_req  = reset && req_int;
    assign imem.imem_addr = pc_q;
    assign instn_out      = instn_q;
    assign currpc         = currpc_q;
    assign nextpc         = nextpc_q;
    assign instn_valid    = valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (!valid_q && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_q <= 16'd0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - table-driven bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instn_out, currpc, nextpc;
    logic        instn_valid;
    logic [31:0] instn_out1, currpc1, nextpc1;
    logic        instn_valid1;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    if_fetch_unit_if m0();
    if_fetch_unit_if m1();

    assign m1.imem_ack   = m1.imem_req;
    assign m1.imem_rdata = 32'h5500_0000 ^ m1.imem_addr;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt, bubble_cnt1;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem(m0.master),
        .instn_out(instn_out), .currpc(currpc), .nextpc(nextpc),
        .instn_valid(instn_valid)
`ifdef FETCH_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .reset(reset), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'd0),
        .imem(m1.master),
        .instn_out(instn_out1), .currpc(currpc1), .nextpc(nextpc1),
        .instn_valid(instn_valid1)
`ifdef FETCH_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt1)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instn;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic a, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instn = ei;
        return v;
    endfunction

`ifdef FETCH_BUBBLE_CNT_EN
    logic [15:0] exp_bub = 16'd0;
    logic        bub_armed = 1'b0;

    always @(negedge clk) begin
        #2;
        if (bub_armed) chk("bubble_cnt", {16'd0, bubble_cnt}, {16'd0, exp_bub});
        if (!reset) begin
            exp_bub   = 16'd0;
            bub_armed = 1'b1;
        end else if (bub_armed && !instn_valid && exp_bub != 16'hFFFF) begin
            exp_bub = exp_bub + 16'd1;
        end
    end
`endif

    initial begin
        //          stall br  tgt        ack  rdata         req  addr       valid pc        instn
        tv[0]  = mk(0, 0, 32'h0,     1, 32'hA000_0000, 1, 32'h0,    0, 32'h0,   32'h0);
        tv[1]  = mk(0, 0, 32'h0,     1, 32'hA000_0004, 1, 32'h4,    1, 32'h0,   32'hA000_0000);
        tv[2]  = mk(0, 0, 32'h0,     1, 32'hA000_0008, 1, 32'h8,    1, 32'h4,   32'hA000_0004);
        tv[3]  = mk(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,    1, 32'h8,   32'hA000_0008);
        tv[4]  = mk(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,    1, 32'h8,   32'hA000_0008);
        tv[5]  = mk(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,    1, 32'h8,   32'hA000_0008);
        tv[6]  = mk(0, 0, 32'h0,     1, 32'hA000_000C, 1, 32'hC,    1, 32'h8,   32'hA000_0008);
        tv[7]  = mk(0, 0, 32'h0,     0, 32'h0,         1, 32'h10,   1, 32'hC,   32'hA000_000C);
        tv[8]  = mk(0, 0, 32'h0,     0, 32'h0,         1, 32'h10,   0, 32'h0,   32'h0);
        tv[9]  = mk(0, 1, 32'h103,   0, 32'h0,         1, 32'h10,   0, 32'h0,   32'h0);
        tv[10] = mk(0, 0, 32'h0,     1, 32'hDEAD_BEEF, 1, 32'h100,  0, 32'h0,   32'h0);
        tv[11] = mk(0, 0, 32'h0,     1, 32'hA000_0100, 1, 32'h100,  0, 32'h0,   32'h0);
        tv[12] = mk(0, 1, 32'h40,    1, 32'hBADB_AD00, 1, 32'h104,  1, 32'h100, 32'hA000_0100);
        tv[13] = mk(0, 0, 32'h0,     1, 32'hA000_0040, 1, 32'h40,   0, 32'h0,   32'h0);
        tv[14] = mk(0, 0, 32'h0,     0, 32'h0,         1, 32'h44,   1, 32'h40,  32'hA000_0040);
        tv[15] = mk(0, 1, 32'h200,   0, 32'h0,         1, 32'h44,   0, 32'h0,   32'h0);
        tv[16] = mk(0, 1, 32'h302,   0, 32'h0,         1, 32'h200,  0, 32'h0,   32'h0);
        tv[17] = mk(0, 0, 32'h0,     1, 32'h1111_1111, 1, 32'h300,  0, 32'h0,   32'h0);
        tv[18] = mk(0, 0, 32'h0,     1, 32'hA000_0300, 1, 32'h300,  0, 32'h0,   32'h0);
        tv[19] = mk(1, 0, 32'h0,     0, 32'h0,         0, 32'h0,    1, 32'h300, 32'hA000_0300);
        tv[20] = mk(1, 1, 32'h500,   0, 32'h0,         0, 32'h0,    1, 32'h300, 32'hA000_0300);
        tv[21] = mk(1, 0, 32'h0,     0, 32'h0,         1, 32'h500,  0, 32'h0,   32'h0);
        tv[22] = mk(0, 0, 32'h0,     1, 32'hA000_0500, 1, 32'h500,  0, 32'h0,   32'h0);
        tv[23] = mk(0, 0, 32'h0,     0, 32'h0,         1, 32'h504,  1, 32'h500, 32'hA000_0500);

        m0.imem_ack   = 1'b0;
        m0.imem_rdata = 32'd0;

        @(negedge clk); #1;
        chk("rst_req", {31'd0, m0.imem_req}, 32'd0);
        @(negedge clk); #1;
        chk("rst_valid",  {31'd0, instn_valid}, 32'd0);
        chk("rst_currpc", currpc, 32'd0);
        chk("rst_nextpc", nextpc, 32'd0);
        chk("rst_instn",  instn_out, 32'd0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            reset         = 1'b1;
            stall         = tv[i].stall;
            branch_taken  = tv[i].br;
            branch_target = tv[i].tgt;
            m0.imem_ack   = tv[i].ack;
            m0.imem_rdata = tv[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'd0, m0.imem_req}, {31'd0, tv[i].e_req});
            if (tv[i].e_req) chk($sformatf("v%0d_addr", i), m0.imem_addr, tv[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, instn_valid}, {31'd0, tv[i].e_valid});
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d_currpc", i), currpc, tv[i].e_pc);
                chk($sformatf("v%0d_nextpc", i), nextpc, tv[i].e_pc + 32'd4);
                chk($sformatf("v%0d_instn", i), instn_out, tv[i].e_instn);
            end
            if (i == 0) chk("wrap_first_addr", m1.imem_addr, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("wrap_valid",  {31'd0, instn_valid1}, 32'd1);
                chk("wrap_currpc", currpc1, 32'hFFFF_FFFC);
                chk("wrap_nextpc", nextpc1, 32'h0);
                chk("wrap_next_addr", m1.imem_addr, 32'h0);
            end
        end

        // Reset while a request is outstanding: pending ack must be dropped.
        @(negedge clk);
        reset         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        m0.imem_ack   = 1'b1;
        m0.imem_rdata = 32'hEEEE_EEEE;
        #1;
        chk("midwait_rst_req", {31'd0, m0.imem_req}, 32'd0);
        @(negedge clk);
        reset         = 1'b1;
        m0.imem_ack   = 1'b1;
        m0.imem_rdata = 32'hC000_0000;
        #1;
        chk("midwait_valid",  {31'd0, instn_valid}, 32'd0);
        chk("midwait_currpc", currpc, 32'd0);
        chk("midwait_instn",  instn_out, 32'd0);
        chk("midwait_req",    {31'd0, m0.imem_req}, 32'd1);
        chk("midwait_addr",   m0.imem_addr, 32'd0);
        @(negedge clk);
        m0.imem_ack = 1'b0;
        #1;
        chk("post_rst_valid",  {31'd0, instn_valid}, 32'd1);
        chk("post_rst_currpc", currpc, 32'd0);
        chk("post_rst_instn",  instn_out, 32'hC000_0000);
        chk("post_rst_addr",   m0.imem_addr, 32'd4);
        repeat (3) @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
